// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit 7-segment scanner with per-digit
// decimal point, blanking, blink and anti-ghosting dead time.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000,
    parameter int BLINK_DIV   = 25000000,
    parameter int HEX_EN      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [0:6]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  ph;
    logic [3:0]            val;
    logic                  dpl;
    logic                  blk;
    logic                  bm;

    logic                  at_wrap;
    logic                  b_wrap;
    logic [IW-1:0]         nidx;
    logic                  dead;
    logic                  dark;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] anodes_n;

    assign at_wrap = (cnt == CMAX);
    assign b_wrap  = (bcnt == BMAX);
    assign nidx    = (idx == IMAX) ? '0 : idx + 1'b1;
    assign dead    = (cnt < DEAD);
    assign dark    = blk | (bm & ph) | ~en | dead;

    // Glyph lookup for the latched value, a..g MSB first, 0 = lit.
    always_comb begin
        case (val)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
        if (HEX_EN == 0 && val > 4'd9) begin
            glyph = 7'b1111111;
        end
    end

    // Only the scanned digit's anode is pulled low, outside dead time.
    always_comb begin
        anodes_n = '1;
        if (en && !dead) begin
            anodes_n[idx] = 1'b0;
        end
    end

    // Scan and blink counters, slot snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            bcnt      <= '0;
            ph        <= 1'b0;
            val       <= 4'h0;
            dpl       <= 1'b0;
            blk       <= 1'b1;
            bm        <= 1'b0;
            anodes    <= '1;
            segments  <= '1;
            dp        <= 1'b1;
            digit_idx <= '0;
        end else begin
            if (at_wrap) begin
                cnt <= '0;
                idx <= nidx;
                val <= digits[4*nidx +: 4];
                dpl <= dp_in[nidx];
                blk <= blank[nidx];
                bm  <= blink_mask[nidx];
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (b_wrap) begin
                bcnt <= '0;
                ph   <= ~ph;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
            anodes    <= anodes_n;
            segments  <= dark ? 7'b1111111 : glyph;
            dp        <= dark | ~dpl;
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed vectors, hand sequences and random stimulus
// checked against a time-indexed reference model of the scanner.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 2;
    localparam int BD = 64;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink_mask = '0;

    logic [0:6]  seg_h, seg_n;
    logic        dp_h, dp_n;
    logic [3:0]  an_h, an_n;
    logic [1:0]  di_h, di_n;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
        .BLINK_DIV(BD), .HEX_EN(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits),
        .dp_in(dp_in), .blank(blank), .blink_mask(blink_mask),
        .segments(seg_h), .dp(dp_h), .anodes(an_h), .digit_idx(di_h)
    );

    seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
        .BLINK_DIV(BD), .HEX_EN(0)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits),
        .dp_in(dp_in), .blank(blank), .blink_mask(blink_mask),
        .segments(seg_n), .dp(dp_n), .anodes(an_n), .digit_idx(di_n)
    );

    int errors = 0;
    int checks = 0;

    // model: s = clock edges since reset release, plus latched slot data
    int         s = 0;
    logic [3:0] sv = '0;
    logic       sd = 1'b0;
    logic       sb = 1'b1;
    logic       sm = 1'b0;

    typedef struct {
        logic [3:0] val;
        logic [6:0] hex;
        logic [6:0] dec;
    } vec_t;
    vec_t vec [16];

    function automatic logic [6:0] ref_glyph(input logic [3:0] v,
                                             input bit hex);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        if (!hex && v > 4'd9) return 7'b1111111;
        return t[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        int cnt, idx, ph, ni;
        bit dead, dark;
        logic [3:0] ea;
        logic [6:0] eh, ed;
        logic edp;
        cnt  = s % RD;
        idx  = (s / RD) % ND;
        ph   = (s / BD) % 2;
        dead = cnt < DC;
        dark = sb || (sm && ph == 1) || !en || dead;
        ea   = (!en || dead) ? 4'hF : ~(4'b0001 << idx);
        eh   = dark ? 7'h7F : ref_glyph(sv, 1'b1);
        ed   = dark ? 7'h7F : ref_glyph(sv, 1'b0);
        edp  = dark ? 1'b1 : ~sd;
        @(posedge clk);
        if (cnt == RD - 1) begin
            ni = ((s + 1) / RD) % ND;
            sv = digits[4*ni +: 4];
            sd = dp_in[ni];
            sb = blank[ni];
            sm = blink_mask[ni];
        end
        s++;
        #1;
        chk("anodes", an_h, ea);
        chk("segments", seg_h, eh);
        chk("dp", dp_h, edp);
        chk("digit_idx", di_h, idx);
        chk("segments_nohex", seg_n, ed);
        chk("anodes_nohex", an_n, ea);
    endtask

    // advance until the last output shows frame phase ph (0..FR-1)
    task automatic run_to(input int ph);
        int n;
        tick();
        n = 1;
        while (((s - 1) % FR) != ph && n < 2 * FR) begin
            tick();
            n++;
        end
        chk("run_to_timeout", (s - 1) % FR, ph);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_anodes", an_h, 4'hF);
        chk("rst_segments", seg_h, 7'h7F);
        chk("rst_dp", dp_h, 1'b1);
        chk("rst_idx", di_h, 2'd0);
        chk("rst_segments_nohex", seg_n, 7'h7F);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s  = 0;
        sv = '0;
        sd = 1'b0;
        sb = 1'b1;
        sm = 1'b0;
    endtask

    task automatic scan_scenario();
        for (int k = 1; k <= 5 * RD; k++) begin
            tick();
            if (k <= RD) chk("first_slot_dark", seg_h, 7'h7F);
            if (k == 3) chk("slot0_anode", an_h, 4'b1110);
            if (k == 11) begin
                chk("slot1_anode", an_h, 4'b1101);
                chk("slot1_seg", seg_h, 7'b0010010);
            end
            if (k == 35) begin
                chk("slot4_anode", an_h, 4'b1110);
                chk("slot4_seg", seg_h, 7'b1001111);
            end
            if (k == 33) chk("slot4_dead", an_h, 4'hF);
        end
    endtask

    initial begin
        int lit0, dark0, odark;
        logic [6:0] hx [4];
        logic [6:0] dx [4];
        logic [3:0] ax [4];

        vec[0]  = '{4'h0, 7'b0000001, 7'b0000001};
        vec[1]  = '{4'h1, 7'b1001111, 7'b1001111};
        vec[2]  = '{4'h2, 7'b0010010, 7'b0010010};
        vec[3]  = '{4'h3, 7'b0000110, 7'b0000110};
        vec[4]  = '{4'h4, 7'b1001100, 7'b1001100};
        vec[5]  = '{4'h5, 7'b0100100, 7'b0100100};
        vec[6]  = '{4'h6, 7'b0100000, 7'b0100000};
        vec[7]  = '{4'h7, 7'b0001111, 7'b0001111};
        vec[8]  = '{4'h8, 7'b0000000, 7'b0000000};
        vec[9]  = '{4'h9, 7'b0000100, 7'b0000100};
        vec[10] = '{4'hA, 7'b0001000, 7'b1111111};
        vec[11] = '{4'hB, 7'b1100000, 7'b1111111};
        vec[12] = '{4'hC, 7'b0110001, 7'b1111111};
        vec[13] = '{4'hD, 7'b1000010, 7'b1111111};
        vec[14] = '{4'hE, 7'b0110000, 7'b1111111};
        vec[15] = '{4'hF, 7'b0111000, 7'b1111111};

        #1;
        digits = 16'h4321;
        en = 1'b1;
        do_reset();
        scan_scenario();

        // decode table through digit 1
        for (int i = 0; i < 16; i++) begin
            digits[7:4] = vec[i].val;
            repeat (FR) tick();
            run_to(RD + 4);
            chk("decode_hex", seg_h, vec[i].hex);
            chk("decode_nohex", seg_n, vec[i].dec);
            chk("decode_anode", an_h, 4'b1101);
        end

        // hex digits with digit 2 blanked
        digits = 16'hFA90;
        blank = 4'b0100;
        hx = '{7'b0000001, 7'b0000100, 7'h7F, 7'b0111000};
        dx = '{7'b0000001, 7'b0000100, 7'h7F, 7'h7F};
        ax = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        repeat (FR) tick();
        for (int d = 0; d < ND; d++) begin
            run_to(d * RD + 4);
            chk("hexblank_seg", seg_h, hx[d]);
            chk("hexblank_seg_nohex", seg_n, dx[d]);
            chk("hexblank_anode", an_h, ax[d]);
        end

        // blink on digit 0 with its decimal point lit
        blank = 4'b0000;
        digits = 16'h4321;
        blink_mask = 4'b0001;
        dp_in = 4'b0001;
        lit0 = 0;
        dark0 = 0;
        odark = 0;
        repeat (FR) tick();
        for (int k = 0; k < 4 * BD; k++) begin
            tick();
            if (an_h == 4'b1110) begin
                if (seg_h == 7'b1001111 && dp_h == 1'b0) lit0++;
                if (seg_h == 7'h7F && dp_h == 1'b1) dark0++;
            end else if (an_h != 4'hF && seg_h == 7'h7F) begin
                odark++;
            end
        end
        chk("blink_lit_seen", lit0 > 0, 1'b1);
        chk("blink_dark_seen", dark0 > 0, 1'b1);
        chk("blink_others_lit", odark, 0);

        // mid-slot input change is held off until the next slot
        blink_mask = 4'b0000;
        dp_in = 4'b0000;
        repeat (FR) tick();
        run_to(4);
        digits[3:0] = 4'h7;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("snapshot_hold", seg_h, 7'b1001111);
        end
        run_to(2);
        chk("snapshot_new", seg_h, 7'b0001111);

        // display disable with free-running counters
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("dis_anodes", an_h, 4'hF);
            chk("dis_segments", seg_h, 7'h7F);
            chk("dis_dp", dp_h, 1'b1);
        end
        en = 1'b1;
        repeat (2 * FR) tick();

        // asynchronous reset mid-slot of digit 2
        run_to(2 * RD + 5);
        digits = 16'h4321;
        do_reset();
        scan_scenario();

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7) == 0) begin
                digits = 16'($urandom);
                dp_in = 4'($urandom_range(15));
                blank = 4'($urandom_range(15) & $urandom_range(15));
                blink_mask = 4'($urandom_range(15));
            end
            if ($urandom_range(49) == 0) en = ~en;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
